csr_file_m: RTL

- Machine-mode CSR file with an integrated trap/return unit.
- Parametrised successor of the basic CSR bank, adding:
  - CSR RW/RS/RC operations and illegal-access detection
  - writable mstatus.MIE/MPIE
  - 64-bit mcycle/minstret counters
  - live interrupt pending, with request and cause generation
  - trap entry and mret redirect
- Sits beside the execute stage. Decode supplies CSR ops; the pipeline supplies trap/retire/mret events.

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_file_m_counter.sv | 41 ++++
 rtl/csr_file_m.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// status/interrupt bit positions and trap cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIP_MSIP_BIT     = 3;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

  localparam logic [4:0] EXC_CODE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] EXC_CODE_ECALL_M       = 5'd11;

endpackage

// File: rtl/csr_file_m_counter.sv
// 64-bit event counter with independent half writes; a write to either half
// suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rstl_i,
  input  logic        inc_en_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Next count: half writes win, otherwise increment with natural 64-bit wrap
  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      count_d = {(wr_hi_i ? wdata_hi_i : count_q[63:32]),
                 (wr_lo_i ? wdata_lo_i : count_q[31:0])};
    end else if (inc_en_i) begin
      count_d = count_q + 64'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rstl_i) begin
    if (!rstl_i) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file with trap entry, mret return, cycle/instret counters
// and interrupt request generation.
module csr_file_m
  import csr_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [25:0]      MISA_EXT    = 26'h0000100,
  parameter logic [XLEN-1:0]  HART_ID     = '0,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rstl,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0]      MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam bit              RV32      = (XLEN == 32);
  localparam logic [XLEN-1:0] MIE_WMASK = XLEN'(12'h888);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;

  logic [63:0]     mcycle_s, minstret_s, wval64_s;
  logic [XLEN-1:0] old_s, wval_s, pend_s, tvec_base_s;
  logic            impl_s, wants_write_s, illegal_s, csr_we_s, vectored_s;
  logic            cyc_wr_lo_s, cyc_wr_hi_s, ins_wr_lo_s, ins_wr_hi_s;
  logic [31:0]     cnt_wdata_hi_s;

  // Current value of the addressed CSR and whether the address exists
  always_comb begin
    old_s  = '0;
    impl_s = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_s[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        old_s[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        old_s[12:11]            = 2'b11;
      end
      CSR_MISA: begin
        old_s[XLEN-1 -: 2] = MXL;
        old_s[25:0]        = MISA_EXT;
      end
      CSR_MIE:       old_s = mie_q;
      CSR_MTVEC:     old_s = mtvec_q;
      CSR_MSCRATCH:  old_s = mscratch_q;
      CSR_MEPC:      old_s = mepc_q;
      CSR_MCAUSE:    old_s = mcause_q;
      CSR_MTVAL:     old_s = mtval_q;
      CSR_MIP:       old_s = mip_q;
      CSR_MCYCLE:    old_s = mcycle_s[XLEN-1:0];
      CSR_MINSTRET:  old_s = minstret_s[XLEN-1:0];
      CSR_MCYCLEH: begin
        if (RV32) old_s = XLEN'(mcycle_s[63:32]);
        else      impl_s = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (RV32) old_s = XLEN'(minstret_s[63:32]);
        else      impl_s = 1'b0;
      end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: old_s = '0;
      CSR_MHARTID:   old_s = HART_ID;
      default:       impl_s = 1'b0;
    endcase
  end

  // RS/RC with a zero mask is a pure read, so it may target read-only space
  assign wants_write_s = (csr_op == CSR_OP_RW) ||
                         ((csr_op != CSR_OP_NONE) && (csr_wdata != '0));
  assign illegal_s     = (csr_op != CSR_OP_NONE) &&
                         (!impl_s || ((csr_addr[11:10] == 2'b11) && wants_write_s));
  assign csr_we_s      = wants_write_s && !illegal_s && !trap_valid && !mret;
  assign csr_illegal   = illegal_s;
  assign csr_rdata     = illegal_s ? '0 : old_s;

  // Value a CSR instruction would write
  always_comb begin
    case (csr_op)
      CSR_OP_RW: wval_s = csr_wdata;
      CSR_OP_RS: wval_s = old_s | csr_wdata;
      CSR_OP_RC: wval_s = old_s & ~csr_wdata;
      default:   wval_s = old_s;
    endcase
  end

  assign wval64_s       = 64'(wval_s);
  assign cnt_wdata_hi_s = RV32 ? wval64_s[31:0] : wval64_s[63:32];
  assign cyc_wr_lo_s    = csr_we_s && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi_s    = csr_we_s && (RV32 ? (csr_addr == CSR_MCYCLEH) : (csr_addr == CSR_MCYCLE));
  assign ins_wr_lo_s    = csr_we_s && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi_s    = csr_we_s && (RV32 ? (csr_addr == CSR_MINSTRETH) : (csr_addr == CSR_MINSTRET));

  csr_counter64 u_mcycle (
    .clk_i      (clk),
    .rstl_i     (rstl),
    .inc_en_i   (1'b1),
    .wr_lo_i    (cyc_wr_lo_s),
    .wr_hi_i    (cyc_wr_hi_s),
    .wdata_lo_i (wval64_s[31:0]),
    .wdata_hi_i (cnt_wdata_hi_s),
    .count_o    (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk_i      (clk),
    .rstl_i     (rstl),
    .inc_en_i   (retire),
    .wr_lo_i    (ins_wr_lo_s),
    .wr_hi_i    (ins_wr_hi_s),
    .wdata_lo_i (wval64_s[31:0]),
    .wdata_hi_i (cnt_wdata_hi_s),
    .count_o    (minstret_s)
  );

  // Next architectural state: trap beats mret beats CSR write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mtvec_d        = mtvec_q;
    mip_d          = '0;
    mip_d[MIP_MEIP_BIT] = irq_ext;
    mip_d[MIP_MTIP_BIT] = irq_timer;
    mip_d[MIP_MSIP_BIT] = irq_soft;
    if (trap_valid) begin
      mepc_d         = {trap_pc[XLEN-1:1], 1'b0};
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wval_s[MSTATUS_MIE_BIT];
          mstatus_mpie_d = wval_s[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = wval_s & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = {wval_s[XLEN-1:2], (wval_s[1] ? 2'b00 : wval_s[1:0])};
        CSR_MSCRATCH: mscratch_d = wval_s;
        CSR_MEPC:     mepc_d     = {wval_s[XLEN-1:1], 1'b0};
        CSR_MCAUSE:   mcause_d   = wval_s;
        CSR_MTVAL:    mtval_d    = wval_s;
        default: begin
        end
      endcase
    end else begin
      mepc_d = mepc_q;
    end
  end

  // Architectural CSR registers
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mtvec_q        <= MTVEC_RESET;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mtvec_q        <= mtvec_d;
    end
  end

  assign tvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};
  assign vectored_s  = (mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1];

  // PC redirect for trap entry or mret
  always_comb begin
    redirect_valid = trap_valid || mret;
    if (trap_valid) begin
      redirect_pc = tvec_base_s + (vectored_s ? {trap_cause[XLEN-3:0], 2'b00} : '0);
    end else if (mret) begin
      redirect_pc = mepc_q;
    end else begin
      redirect_pc = '0;
    end
  end

  assign pend_s  = mip_q & mie_q;
  assign irq_req = mstatus_mie_q && (pend_s != '0);

  // Interrupt cause, external first, then software, then timer
  always_comb begin
    irq_cause = '0;
    if (irq_req) begin
      irq_cause[XLEN-1] = 1'b1;
      if (pend_s[MIP_MEIP_BIT])      irq_cause[4:0] = IRQ_CODE_MEI;
      else if (pend_s[MIP_MSIP_BIT]) irq_cause[4:0] = IRQ_CODE_MSI;
      else                           irq_cause[4:0] = IRQ_CODE_MTI;
    end else begin
      irq_cause = '0;
    end
  end

endmodule
